// File: rtl/forward_history_updater.sv
// forward_history_updater
//   Forwarding unit for the hash-table read-modify-write pipeline. It keeps a
//   shift history of the last DEPTH RAM write-backs. A lookup's slot, as read
//   from RAM, is replaced by the youngest matching in-flight write. The
//   priority order is: the same-cycle write-back (bypass), then history
//   entry 0 (youngest) through entry DEPTH-1. The result is registered once.
//
//   Optional feature macro: FWD_HIT_CNT_EN adds the saturating hit_cnt_o
//   counter.
//
// Ports
//   clk, reset (async, active-low), clk_en (pipeline advance), flush_i
//   lk_*        lookup request, address and slot contents read from RAM
//   wb_*        write-back strobe, address and slot contents written to RAM
//   correct_*   registered forwarded slot; correct_req_o is the registered lk_req_i
//   fwd_hit_o   registered "slot came from bypass/history"
//   hit_cnt_o   forwarding hit count (FWD_HIT_CNT_EN only)
module forward_history_updater #(
    parameter int unsigned DATA_WIDTH           = 4,
    parameter int unsigned KEY_WIDTH            = 2,
    parameter int unsigned HASH_ADR_WIDTH       = 2,
    parameter int unsigned SHIFT_HASH_ADR_WIDTH = 2,
    parameter int unsigned DEPTH                = 3,
    parameter int unsigned HIT_CNT_WIDTH        = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clk_en,
    input  logic                            flush_i,
    input  logic                            lk_req_i,
    input  logic [HASH_ADR_WIDTH-1:0]       lk_hash_adr_i,
    input  logic [KEY_WIDTH-1:0]            lk_key_i,
    input  logic [DATA_WIDTH-1:0]           lk_data_i,
    input  logic                            lk_valid_i,
    input  logic [SHIFT_HASH_ADR_WIDTH-1:0] lk_shift_adr_i,
    input  logic                            lk_shift_valid_i,
    input  logic                            wb_updated_mem_i,
    input  logic [HASH_ADR_WIDTH-1:0]       wb_hash_adr_i,
    input  logic [KEY_WIDTH-1:0]            wb_key_i,
    input  logic [DATA_WIDTH-1:0]           wb_data_i,
    input  logic                            wb_valid_i,
    input  logic [SHIFT_HASH_ADR_WIDTH-1:0] wb_shift_adr_i,
    input  logic                            wb_shift_valid_i,
    output logic                            correct_req_o,
    output logic [KEY_WIDTH-1:0]            correct_key,
    output logic [DATA_WIDTH-1:0]           correct_data,
    output logic                            correct_is_valid,
    output logic [SHIFT_HASH_ADR_WIDTH-1:0] correct_shift_hash_adr,
    output logic                            correct_shift_valid,
    output logic                            fwd_hit_o
`ifdef FWD_HIT_CNT_EN
    ,
    output logic [HIT_CNT_WIDTH-1:0]        hit_cnt_o
`endif
);

    if (DEPTH < 1 || DEPTH > 8 || HIT_CNT_WIDTH < 1) begin : g_param_check
        $error("forward_history_updater: DEPTH must be 1..8 and HIT_CNT_WIDTH >= 1");
    end

    typedef struct packed {
        logic [KEY_WIDTH-1:0]            key;
        logic [DATA_WIDTH-1:0]           data;
        logic                            is_valid;
        logic [SHIFT_HASH_ADR_WIDTH-1:0] shift_adr;
        logic                            shift_valid;
    } slot_t;

    logic                      r_hist_vld  [DEPTH];
    logic [HASH_ADR_WIDTH-1:0] r_hist_adr  [DEPTH];
    slot_t                     r_hist_slot [DEPTH];

    slot_t w_lk_slot;
    slot_t w_wb_slot;
    slot_t w_sel_slot;
    logic  w_match;

    assign w_lk_slot = '{key: lk_key_i, data: lk_data_i, is_valid: lk_valid_i,
                         shift_adr: lk_shift_adr_i, shift_valid: lk_shift_valid_i};
    assign w_wb_slot = '{key: wb_key_i, data: wb_data_i, is_valid: wb_valid_i,
                         shift_adr: wb_shift_adr_i, shift_valid: wb_shift_valid_i};

    // Scan from oldest to youngest so a younger match overwrites an older one;
    // the bypass is applied last and therefore has the highest priority.
    // A flush suppresses all forwarding for the same-cycle lookup.
    always_comb begin
        w_sel_slot = w_lk_slot;
        w_match    = 1'b0;
        if (!flush_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (r_hist_vld[DEPTH-1-i] && (r_hist_adr[DEPTH-1-i] == lk_hash_adr_i)) begin
                    w_match    = 1'b1;
                    w_sel_slot = r_hist_slot[DEPTH-1-i];
                end
            end
            if (wb_updated_mem_i && (wb_hash_adr_i == lk_hash_adr_i)) begin
                w_match    = 1'b1;
                w_sel_slot = w_wb_slot;
            end
        end
    end

    // History: flush takes effect regardless of clk_en and drops the same-cycle write-back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_hist_vld[i]  <= 1'b0;
                r_hist_adr[i]  <= '0;
                r_hist_slot[i] <= '0;
            end
        end else if (flush_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_hist_vld[i] <= 1'b0;
            end
        end else if (clk_en && wb_updated_mem_i) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_hist_vld[i]  <= r_hist_vld[i-1];
                r_hist_adr[i]  <= r_hist_adr[i-1];
                r_hist_slot[i] <= r_hist_slot[i-1];
            end
            r_hist_vld[0]  <= 1'b1;
            r_hist_adr[0]  <= wb_hash_adr_i;
            r_hist_slot[0] <= w_wb_slot;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            correct_req_o          <= 1'b0;
            correct_key            <= '0;
            correct_data           <= '0;
            correct_is_valid       <= 1'b0;
            correct_shift_hash_adr <= '0;
            correct_shift_valid    <= 1'b0;
            fwd_hit_o              <= 1'b0;
        end else if (clk_en) begin
            correct_req_o          <= lk_req_i;
            correct_key            <= w_sel_slot.key;
            correct_data           <= w_sel_slot.data;
            correct_is_valid       <= w_sel_slot.is_valid;
            correct_shift_hash_adr <= w_sel_slot.shift_adr;
            correct_shift_valid    <= w_sel_slot.shift_valid;
            fwd_hit_o              <= w_match & lk_req_i;
        end
    end

`ifdef FWD_HIT_CNT_EN
    // Saturating count of forwarded lookups; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_o <= '0;
        end else if (clk_en && lk_req_i && w_match && (hit_cnt_o != '1)) begin
            hit_cnt_o <= hit_cnt_o + 1'b1;
        end
    end
`endif

endmodule
